// File: rtl/rq_tlp_arbiter.sv
// Packet-level round-robin arbiter merging several TLP sources onto the RQ stream.
// Whole packets only; registered 2-entry skid buffer on the output.
module rq_tlp_arbiter #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 4,
   parameter int NUM_PORTS  = 2
) (
   input  logic                             user_clk,
   input  logic                             user_reset_n,
   input  logic [NUM_PORTS-1:0]             s_tvalid,
   output logic [NUM_PORTS-1:0]             s_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep,
   input  logic [NUM_PORTS-1:0]             s_tlast,
   input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
   output logic                             m_axis_rq_tvalid,
   input  logic                             m_axis_rq_tready,
   output logic [DATA_WIDTH-1:0]            m_axis_rq_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_rq_tkeep,
   output logic                             m_axis_rq_tlast,
   output logic [USER_WIDTH-1:0]            m_axis_rq_tuser,
   output logic [2:0]                       grant_idx,
   output logic                             busy,
   output logic [15:0]                      pkt_count
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

   state_t                 state_q, state_d;
   logic [2:0]             rr_q, rr_d;
   logic [2:0]             grant_q, grant_d;
   logic                   can_accept_q;

   logic                   found;
   logic [2:0]             winner;
   logic [2:0]             sel;

   logic                   in_valid;
   logic [DATA_WIDTH-1:0]  in_data;
   logic [KEEP_WIDTH-1:0]  in_keep;
   logic                   in_last;
   logic [USER_WIDTH-1:0]  in_user;
   logic                   push;

   logic                   hv_q, hv_d;
   logic                   sv_q, sv_d;
   logic                   pop;
   logic                   ld_head_in, ld_head_skid, ld_skid;

   logic [DATA_WIDTH-1:0]  head_data, skid_data;
   logic [KEEP_WIDTH-1:0]  head_keep, skid_keep;
   logic                   head_last, skid_last;
   logic [USER_WIDTH-1:0]  head_user, skid_user;
   logic [15:0]            pkt_q;

   function automatic logic [2:0] next_port(input logic [2:0] p);
      return (p == LAST_PORT) ? 3'd0 : p + 3'd1;
   endfunction

   // Round-robin search starting at rr_q for the first requesting port
   always_comb begin
      found  = 1'b0;
      winner = 3'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!found && s_tvalid[(int'(rr_q) + i) % NUM_PORTS]) begin
            found  = 1'b1;
            winner = 3'((int'(rr_q) + i) % NUM_PORTS);
         end
      end
   end

   // Source select: fresh winner when idle, held grant while locked
   always_comb begin
      sel = (state_q == IDLE) ? winner : grant_q;
   end

   // Input beat mux from the selected port
   always_comb begin
      in_valid = 1'b0;
      in_data  = '0;
      in_keep  = '0;
      in_last  = 1'b0;
      in_user  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (3'(i) == sel) begin
            in_valid = s_tvalid[i];
            in_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            in_keep  = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            in_last  = s_tlast[i];
            in_user  = s_tuser[i*USER_WIDTH +: USER_WIDTH];
         end
      end
   end

   // Arbitration FSM: next state, pointer/grant updates and per-port ready
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      grant_d  = grant_q;
      s_tready = '0;
      push     = can_accept_q && in_valid;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (3'(i) == sel && (state_q == LOCKED || found))
            s_tready[i] = can_accept_q;
      end
      unique case (state_q)
         IDLE: begin
            if (push) begin
               grant_d = winner;
               if (in_last) rr_d = next_port(winner);
               else         state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (push && in_last) begin
               state_d = IDLE;
               rr_d    = next_port(grant_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Skid buffer occupancy: head feeds the output, skid catches one extra beat
   always_comb begin
      pop          = hv_q && m_axis_rq_tready;
      hv_d         = hv_q;
      sv_d         = sv_q;
      ld_head_in   = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
      if (pop) begin
         if (sv_q) begin
            ld_head_skid = 1'b1;
            sv_d         = 1'b0;
         end else begin
            hv_d = 1'b0;
         end
      end
      if (push) begin
         if (!hv_d) begin
            ld_head_in = 1'b1;
            hv_d       = 1'b1;
         end else begin
            ld_skid = 1'b1;
            sv_d    = 1'b1;
         end
      end
   end

   // Control state, occupancy, registered ready and packet counter
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state_q      <= IDLE;
         rr_q         <= 3'd0;
         grant_q      <= 3'd0;
         hv_q         <= 1'b0;
         sv_q         <= 1'b0;
         can_accept_q <= 1'b0;
         pkt_q        <= 16'd0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         grant_q      <= grant_d;
         hv_q         <= hv_d;
         sv_q         <= sv_d;
         can_accept_q <= !sv_d;
         if (pop && head_last)
            pkt_q <= pkt_q + 16'd1;
      end
   end

   // Beat storage; qualified by the valid flags so it needs no reset
   always_ff @(posedge user_clk) begin
      if (ld_head_in) begin
         head_data <= in_data;
         head_keep <= in_keep;
         head_last <= in_last;
         head_user <= in_user;
      end else if (ld_head_skid) begin
         head_data <= skid_data;
         head_keep <= skid_keep;
         head_last <= skid_last;
         head_user <= skid_user;
      end
      if (ld_skid) begin
         skid_data <= in_data;
         skid_keep <= in_keep;
         skid_last <= in_last;
         skid_user <= in_user;
      end
   end

   assign m_axis_rq_tvalid = hv_q;
   assign m_axis_rq_tdata  = head_data;
   assign m_axis_rq_tkeep  = head_keep;
   assign m_axis_rq_tlast  = head_last;
   assign m_axis_rq_tuser  = head_user;
   assign grant_idx        = grant_q;
   assign busy             = (state_q == LOCKED);
   assign pkt_count        = pkt_q;

endmodule

// File: tb/tb_rq_tlp_arbiter.sv
// Directed bench for rq_tlp_arbiter, two 32-bit ports.
// Output beats are logged and compared against hand-built expected lists.
module tb_rq_tlp_arbiter;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam int UW = 4;
   localparam int NP = 2;

   logic              user_clk;
   logic              user_reset_n;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tready;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*KW-1:0]  s_tkeep;
   logic [NP-1:0]     s_tlast;
   logic [NP*UW-1:0]  s_tuser;
   logic              m_tvalid;
   logic              m_tready;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic              m_tlast;
   logic [UW-1:0]     m_tuser;
   logic [2:0]        grant_idx;
   logic              busy;
   logic [15:0]       pkt_count;

   rq_tlp_arbiter #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .NUM_PORTS(NP)
   ) dut (
      .user_clk(user_clk),
      .user_reset_n(user_reset_n),
      .s_tvalid(s_tvalid),
      .s_tready(s_tready),
      .s_tdata(s_tdata),
      .s_tkeep(s_tkeep),
      .s_tlast(s_tlast),
      .s_tuser(s_tuser),
      .m_axis_rq_tvalid(m_tvalid),
      .m_axis_rq_tready(m_tready),
      .m_axis_rq_tdata(m_tdata),
      .m_axis_rq_tkeep(m_tkeep),
      .m_axis_rq_tlast(m_tlast),
      .m_axis_rq_tuser(m_tuser),
      .grant_idx(grant_idx),
      .busy(busy),
      .pkt_count(pkt_count)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int onehot_viol = 0;
   int side_viol   = 0;
   int in_cnt [NP];

   logic [32:0] q0 [$];
   logic [32:0] q1 [$];
   logic [32:0] outq [$];
   int          out_c [$];
   logic [32:0] expq [$];
   logic [2:0]  gq [$];
   logic [NP-1:0] acc;
   logic [NP-1:0] hold;
   logic [32:0] b0, b1;

   initial begin
      user_clk = 1'b0;
      forever #5 user_clk = ~user_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int p, input logic [31:0] d, input logic l);
      if (p == 0) q0.push_back({l, d});
      else        q1.push_back({l, d});
   endtask

   task automatic wait_out(input int n, input int limit);
      for (int k = 0; k < limit && outq.size() < n; k++) begin
         @(negedge user_clk); #2;
      end
      repeat (3) @(negedge user_clk);
      #2;
   endtask

   task automatic cmp_out(input string tag, input bit contig);
      check({tag, "_count"}, 64'(outq.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size(); i++) begin
         if (i < outq.size()) begin
            check(tag, 64'(outq[i]), 64'(expq[i]));
            if (contig)
               check({tag, "_gap"}, 64'(out_c[i] - out_c[0]), 64'(i));
         end
      end
      outq.delete();
      out_c.delete();
      expq.delete();
   endtask

   always @(posedge user_clk) cyc++;

   // Source drivers: advance a port's queue after its beat was accepted
   always @(posedge user_clk) begin
      #1;
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      b0 = (q0.size() > 0) ? q0[0] : '0;
      b1 = (q1.size() > 0) ? q1[0] : '0;
      s_tvalid[0]      = (q0.size() > 0) && !hold[0];
      s_tvalid[1]      = (q1.size() > 0) && !hold[1];
      s_tdata[31:0]    = b0[31:0];
      s_tdata[63:32]   = b1[31:0];
      s_tkeep[3:0]     = b0[3:0];
      s_tkeep[7:4]     = b1[3:0];
      s_tuser[3:0]     = b0[7:4];
      s_tuser[7:4]     = b1[7:4];
      s_tlast[0]       = b0[32];
      s_tlast[1]       = b1[32];
   end

   // Monitor: handshakes seen here complete at the following rising edge
   always @(negedge user_clk) begin
      acc = s_tvalid & s_tready;
      if (acc != '0) gq.push_back(grant_idx);
      for (int p = 0; p < NP; p++) if (acc[p]) in_cnt[p]++;
      if ($countones(s_tready) > 1) onehot_viol++;
      if (m_tvalid && m_tready) begin
         outq.push_back({m_tlast, m_tdata});
         out_c.push_back(cyc);
         if (m_tkeep != m_tdata[3:0] || m_tuser != m_tdata[7:4])
            side_viol++;
      end
   end

   initial begin
      int b;
      user_reset_n = 1'b0;
      m_tready     = 1'b1;
      s_tvalid     = '0;
      s_tdata      = '0;
      s_tkeep      = '0;
      s_tlast      = '0;
      s_tuser      = '0;
      hold         = '0;
      acc          = '0;
      in_cnt[0]    = 0;
      in_cnt[1]    = 0;

      repeat (3) @(negedge user_clk);
      #2;
      check("rst_mvalid", 64'(m_tvalid), 0);
      check("rst_sready", 64'(s_tready), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_grant", 64'(grant_idx), 0);
      check("rst_pkt", 64'(pkt_count), 0);
      @(posedge user_clk); #1;
      user_reset_n = 1'b1;
      repeat (2) @(negedge user_clk);
      #2;

      // Port0 3-beat TLP wins, port1 2-beat TLP follows with no gap
      push(0, 32'hA000_0011, 1'b0);
      push(0, 32'hA000_0022, 1'b0);
      push(0, 32'hA000_0033, 1'b1);
      push(1, 32'hB000_0041, 1'b0);
      push(1, 32'hB000_0052, 1'b1);
      expq = '{33'h0A000_0011, 33'h0A000_0022, 33'h1A000_0033,
               33'h0B000_0041, 33'h1B000_0052};
      wait_out(5, 40);
      cmp_out("two_pkts", 1'b1);
      check("two_pkts_cnt", 64'(pkt_count), 2);

      // Single-beat TLPs on both ports alternate at full rate
      gq.delete();
      for (int k = 0; k < 4; k++) begin
         push(0, {8'hC0, 8'h00, 8'(k), 8'h35}, 1'b1);
         push(1, {8'hC1, 8'h01, 8'(k), 8'h9C}, 1'b1);
      end
      for (int k = 0; k < 4; k++) begin
         expq.push_back({1'b1, 8'hC0, 8'h00, 8'(k), 8'h35});
         expq.push_back({1'b1, 8'hC1, 8'h01, 8'(k), 8'h9C});
      end
      wait_out(8, 40);
      cmp_out("alt", 1'b1);
      check("alt_ngrant", 64'(gq.size()), 8);
      for (int i = 0; i < 8; i++)
         if (i < gq.size()) check("alt_grant", 64'(gq[i]), 64'((i + 1) % 2));
      check("alt_cnt", 64'(pkt_count), 10);

      // Port1 stalls mid-packet; port0 must wait for it
      b = in_cnt[1];
      push(1, 32'hD000_0061, 1'b0);
      push(1, 32'hD000_0072, 1'b0);
      push(1, 32'hD000_0083, 1'b1);
      for (int k = 0; k < 20 && in_cnt[1] == b; k++) begin
         @(negedge user_clk); #2;
      end
      hold[1] = 1'b1;
      push(0, 32'hE000_0014, 1'b0);
      push(0, 32'hE000_0025, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge user_clk); #2;
         check("stall_rdy0", 64'(s_tready[0]), 0);
      end
      check("stall_busy", 64'(busy), 1);
      check("stall_grant", 64'(grant_idx), 1);
      check("stall_mvalid", 64'(m_tvalid), 0);
      hold[1] = 1'b0;
      expq = '{33'h0D000_0061, 33'h0D000_0072, 33'h1D000_0083,
               33'h0E000_0014, 33'h1E000_0025};
      wait_out(5, 40);
      cmp_out("stall", 1'b0);

      // Downstream backpressure: only two beats may be absorbed
      @(posedge user_clk); #1;
      m_tready = 1'b0;
      @(negedge user_clk); #2;
      b = in_cnt[0];
      for (int k = 0; k < 6; k++)
         push(0, {8'hF0, 8'(k), 8'h00, 8'(8'h17 + 8'(k))}, k == 5);
      for (int k = 0; k < 6; k++)
         expq.push_back({k == 5, 8'hF0, 8'(k), 8'h00, 8'(8'h17 + 8'(k))});
      repeat (5) @(negedge user_clk);
      #2;
      check("bp_accepted", 64'(in_cnt[0] - b), 2);
      check("bp_sready", 64'(s_tready), 0);
      check("bp_mvalid", 64'(m_tvalid), 1);
      check("bp_head", 64'(m_tdata), 64'h0000_0000_F000_0017);
      check("bp_noout", 64'(outq.size()), 0);
      @(posedge user_clk); #1;
      m_tready = 1'b1;
      wait_out(6, 60);
      cmp_out("bp", 1'b0);
      check("bp_total_in", 64'(in_cnt[0] - b), 6);
      check("bp_cnt", 64'(pkt_count), 13);

      // Reset in the middle of a packet
      b = in_cnt[0];
      push(0, 32'h9000_00A1, 1'b0);
      push(0, 32'h9000_00B2, 1'b0);
      push(0, 32'h9000_00C3, 1'b1);
      for (int k = 0; k < 20 && in_cnt[0] - b < 2; k++) begin
         @(negedge user_clk); #2;
      end
      @(posedge user_clk); #3;
      check("prerst_busy", 64'(busy), 1);
      user_reset_n = 1'b0;
      #1;
      check("arst_mvalid", 64'(m_tvalid), 0);
      check("arst_sready", 64'(s_tready), 0);
      check("arst_busy", 64'(busy), 0);
      check("arst_grant", 64'(grant_idx), 0);
      check("arst_pkt", 64'(pkt_count), 0);
      q0.delete();
      q1.delete();
      hold = '0;
      repeat (2) @(posedge user_clk);
      #1;
      outq.delete();
      out_c.delete();
      user_reset_n = 1'b1;
      @(negedge user_clk); #2;
      push(1, 32'h5000_0071, 1'b0);
      push(1, 32'h5000_0082, 1'b1);
      push(0, 32'h4000_00E4, 1'b1);
      expq = '{33'h14000_00E4, 33'h05000_0071, 33'h15000_0082};
      wait_out(3, 40);
      cmp_out("post_rst", 1'b0);
      check("post_rst_cnt", 64'(pkt_count), 2);
      check("post_rst_grant", 64'(grant_idx), 1);
      check("post_rst_busy", 64'(busy), 0);

      check("onehot_ready", 64'(onehot_viol), 0);
      check("sideband", 64'(side_viol), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rq_tlp_arbiter.md
Name: rq_tlp_arbiter

Overview:
Packet-level round-robin arbiter that shares the single requester-request (RQ) AXI-Stream path between NUM_PORTS TLP sources, e.g. DMA reader, DMA writer and MSI. It sits upstream of the RQ adapter that converts generic TLPs to the hard-block RQ format. It forwards whole packets only, never interleaving beats of different packets. It has a registered, skid-buffered output.

Parameters:
DATA_WIDTH, 512, beat data width in bits
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width
USER_WIDTH, 4, per-beat sideband (ecrc, poison, -, discontinue), passed through untouched
NUM_PORTS, 2, number of requesters (2..8)

Ports:
user_clk  in  1  clock
user_reset_n  in  1  asynchronous active-low reset
s_tvalid  in  NUM_PORTS  per-port beat valid
s_tready  out  NUM_PORTS  per-port ready
s_tdata  in  NUM_PORTS*DATA_WIDTH  port i at slice [i*DATA_WIDTH +: DATA_WIDTH]
s_tkeep  in  NUM_PORTS*KEEP_WIDTH  per-port keep, same slicing
s_tlast  in  NUM_PORTS  per-port end of packet
s_tuser  in  NUM_PORTS*USER_WIDTH  per-port sideband
m_axis_rq_tvalid  out  1  merged stream valid
m_axis_rq_tready  in  1  downstream ready
m_axis_rq_tdata  out  DATA_WIDTH  merged data
m_axis_rq_tkeep  out  KEEP_WIDTH  merged keep
m_axis_rq_tlast  out  1  merged end of packet
m_axis_rq_tuser  out  USER_WIDTH  merged sideband
grant_idx  out  3  port currently owning the path; valid while busy
busy  out  1  high while in LOCKED state
pkt_count  out  16  packets forwarded, counted on output tlast handshake, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync deassert expected externally): state IDLE, rr_ptr=0, skid buffer empty.
- Reset outputs: m_axis_rq_tvalid=0, s_tready=0, busy=0, grant_idx=0, pkt_count=0.
- Reset mid-packet aborts silently. No tlast is emitted for the partial packet.
- FSM states:
  - IDLE: combinational pick of the first port with s_tvalid=1, searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
    - If a port is found and the buffer can accept, s_tready[winner]=1 and the beat is taken in the same cycle.
    - If that beat has tlast=1 (single-beat TLP), stay in IDLE, set rr_ptr=winner+1 and grant_idx=winner.
    - Otherwise go to LOCKED with grant_idx=winner.
  - LOCKED: only s_tready[grant_idx] may be high. It equals buffer-can-accept.
    - Accepting a beat with tlast=1 goes to IDLE and sets rr_ptr=grant_idx+1 (mod NUM_PORTS).
- At most one s_tready bit is high in any cycle. Ungranted ports always see s_tready=0.
- Granted port drops s_tvalid mid-packet: stay LOCKED, output starves, no re-arbitration.
- No bubble between packets: a tlast beat accepted at cycle t allows the next packet's first beat to be accepted at t+1.
- Output stage is a 2-entry skid buffer; all m_axis_rq_* outputs are registered.
  - Latency: beat accepted at t with an empty buffer drives m_axis_rq_* at t+1.
  - Buffer-can-accept is registered, derived only from buffer occupancy, with no combinational path from m_axis_rq_tready.
  - Full throughput of 1 beat/cycle when m_axis_rq_tready is held high.
- Output data, keep, last and user are exactly the granted input beat. Order is preserved.
- pkt_count increments on m_axis_rq_tvalid & m_axis_rq_tready & m_axis_rq_tlast.
- Simultaneous tlast accept and new requests: the new arbitration uses the updated rr_ptr next cycle.
- Invariants:
  - rr_ptr is always < NUM_PORTS.
  - Nothing is forwarded with m_axis_rq_tvalid=0.

Test Plan:
- Reset, both ports idle -> m_axis_rq_tvalid=0, s_tready=00, busy=0, pkt_count=0.
- Port0 sends a 3-beat TLP while port1 holds valid from cycle 1, tready=1 -> port0 beats appear at t+1..t+3 unbroken, then port1 packet with no gap; pkt_count=2.
- Both ports stream single-beat TLPs continuously, NUM_PORTS=2 -> output alternates 0,1,0,1; 1 beat/cycle; grant_idx toggles.
- Port1 mid-packet deasserts s_tvalid for 4 cycles while port0 requests -> s_tready[0] stays 0, output idles, port1 completes before port0 is served.
- m_axis_rq_tready low for 5 cycles during a burst -> at most 2 beats buffered, s_tready low after the buffer fills, no beat lost or duplicated on resume; compare against a scoreboard.
- user_reset_n asserted mid-packet -> all outputs return to reset values asynchronously; after release rr_ptr=0 and the first request is served cleanly.
